// File: rtl/music_playback_scheduler.sv
// Playback sequencer for a bank of song memories: selects, resets, gates and muxes one memory.
// Optional `SCHED_AUTO_ADVANCE_EN: end-of-song continues with the next song instead of idling.
module music_playback_scheduler #(
  parameter int N_SONGS       = 4,
  parameter int SEL_W         = 2,
  parameter int DATA_WIDTH    = 10,
  parameter int PRIME_TIMEOUT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          play_req,
  input  logic                          pause_req,
  input  logic                          stop_req,
  input  logic                          next_req,
  input  logic [SEL_W-1:0]              song_sel,
  input  logic [N_SONGS*DATA_WIDTH-1:0] mem_data,
  input  logic [N_SONGS-1:0]            mem_ready,
  output logic [N_SONGS-1:0]            mem_read_en,
  output logic [N_SONGS-1:0]            mem_read_rst,
  output logic [DATA_WIDTH-1:0]         note_out,
  output logic                          note_valid,
  output logic [SEL_W-1:0]              cur_song,
  output logic [2:0]                    state_o,
  output logic                          song_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    PRIME = 3'd2,
    PLAY  = 3'd3,
    PAUSE = 3'd4
  } state_t;

  localparam int CNT_W = $clog2(PRIME_TIMEOUT + 1);

  state_t                  state;
  logic [CNT_W-1:0]        prime_cnt;
  logic                    ready_prev;
  logic                    cur_ready;
  logic [DATA_WIDTH-1:0]   cur_data;
  logic [SEL_W-1:0]        next_song;
  logic [SEL_W-1:0]        sel_clamped;
  logic                    prime_timeout;
  logic                    play_end;
`ifdef SCHED_AUTO_ADVANCE_EN
  logic [SEL_W+1:0]        empty_cnt;
`endif

  function automatic logic [N_SONGS-1:0] onehot(input logic [SEL_W-1:0] idx);
    return N_SONGS'(1) << idx;
  endfunction

  assign cur_ready   = mem_ready[cur_song];
  assign cur_data    = mem_data[cur_song*DATA_WIDTH +: DATA_WIDTH];
  assign next_song   = (cur_song == SEL_W'(N_SONGS - 1)) ? '0 : cur_song + 1'b1;
  assign sel_clamped = ({1'b0, song_sel} < (SEL_W+1)'(N_SONGS)) ? song_sel : '0;
  assign state_o     = state;

  // End-of-song sources, already qualified by the higher-priority requests of their state.
  assign prime_timeout = (state == PRIME) && !next_req && !cur_ready &&
                         (prime_cnt == CNT_W'(PRIME_TIMEOUT - 1));
  assign play_end      = (state == PLAY) && !pause_req && !next_req && ready_prev && !cur_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      prime_cnt    <= '0;
      ready_prev   <= 1'b0;
      mem_read_en  <= '0;
      mem_read_rst <= '0;
      note_out     <= '0;
      note_valid   <= 1'b0;
      cur_song     <= '0;
      song_done    <= 1'b0;
`ifdef SCHED_AUTO_ADVANCE_EN
      empty_cnt    <= '0;
`endif
    end else begin
      song_done    <= 1'b0;
      mem_read_rst <= '0;
      if (stop_req && state != IDLE) begin
        state        <= IDLE;
        mem_read_rst <= onehot(cur_song);
        mem_read_en  <= '0;
        note_valid   <= 1'b0;
      end else if (prime_timeout || play_end) begin
        song_done    <= 1'b1;
        mem_read_rst <= onehot(cur_song);
        mem_read_en  <= '0;
        note_valid   <= 1'b0;
        prime_cnt    <= '0;
`ifdef SCHED_AUTO_ADVANCE_EN
        // A full lap of empty songs means nothing is playable; give up instead of spinning.
        if (prime_timeout && empty_cnt == (SEL_W+2)'(N_SONGS - 1)) begin
          state     <= IDLE;
          empty_cnt <= '0;
        end else begin
          state     <= START;
          cur_song  <= next_song;
          empty_cnt <= prime_timeout ? empty_cnt + 1'b1 : '0;
        end
`else
        state        <= IDLE;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (next_req) begin
              cur_song <= next_song;
            end else if (play_req) begin
              cur_song     <= sel_clamped;
              state        <= START;
              mem_read_rst <= onehot(sel_clamped);
              mem_read_en  <= '0;
              prime_cnt    <= '0;
`ifdef SCHED_AUTO_ADVANCE_EN
              empty_cnt    <= '0;
`endif
            end
          end
          START: begin
            state       <= PRIME;
            mem_read_en <= onehot(cur_song);
            prime_cnt   <= '0;
          end
          PRIME, PLAY, PAUSE: begin
            if (state == PLAY && pause_req) begin
              state       <= PAUSE;
              mem_read_en <= '0;
              note_valid  <= 1'b0;
            end else if (next_req) begin
              // The outgoing song is reset here; every song's pointer is rewound on exit.
              state        <= START;
              mem_read_rst <= onehot(cur_song);
              mem_read_en  <= '0;
              note_valid   <= 1'b0;
              cur_song     <= next_song;
              prime_cnt    <= '0;
            end else if (state == PRIME) begin
              if (cur_ready) begin
                state      <= PLAY;
                note_out   <= cur_data;
                note_valid <= 1'b1;
                ready_prev <= 1'b1;
`ifdef SCHED_AUTO_ADVANCE_EN
                empty_cnt  <= '0;
`endif
              end else begin
                prime_cnt <= prime_cnt + 1'b1;
              end
            end else if (state == PLAY) begin
              note_out   <= cur_data;
              note_valid <= cur_ready;
              ready_prev <= cur_ready;
            end else if (play_req) begin
              state       <= PLAY;
              mem_read_en <= onehot(cur_song);
              note_valid  <= 1'b0;
            end
          end
          default: begin
            state       <= IDLE;
            mem_read_en <= '0;
            note_valid  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/music_playback_scheduler.md
Name: music_playback_scheduler

Overview:
- Sequences playback across N_SONGS song memories: internal preset songs plus the user-recorded memory, all sharing the same read_en / read_rst / data_out / output_ready interface.
- Selects one memory, resets its read pointer, gates its read_en, and muxes its note stream to the tone generator.
- Handles play / pause / stop / next requests and detects end-of-song and empty songs.
- Sits between the keypad/UI FSM and the memory bank.

Parameters:
- N_SONGS, 4, number of song memories attached; index N_SONGS-1 is the user-recorded memory.
- SEL_W, 2, width of song index; must satisfy 2**SEL_W >= N_SONGS.
- DATA_WIDTH, 10, note word width (octave + note one-hot).
- PRIME_TIMEOUT, 8, cycles to wait for output_ready after starting a song before declaring it empty.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- play_req  in  1  start/resume pulse
- pause_req  in  1  pause pulse
- stop_req  in  1  stop pulse
- next_req  in  1  advance to next song (wraps) pulse
- song_sel  in  SEL_W  song index, sampled on play_req from IDLE only
- mem_data  in  N_SONGS*DATA_WIDTH  concatenated data_out of memories; song i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- mem_ready  in  N_SONGS  output_ready of each memory
- mem_read_en  out  N_SONGS  one-hot read enable
- mem_read_rst  out  N_SONGS  one-hot read-pointer reset
- note_out  out  DATA_WIDTH  current note to tone generator
- note_valid  out  1  note_out is valid and audible
- cur_song  out  SEL_W  index of active song
- state_o  out  3  encoded state: IDLE=0, START=1, PRIME=2, PLAY=3, PAUSE=4
- song_done  out  1  one-cycle pulse at end of song or empty-song detection

Behaviour:
- Reset values: mem_read_en=0, mem_read_rst=0, note_out=0, note_valid=0, cur_song=0, state_o=IDLE, song_done=0, prime counter=0.
- All outputs are registered.
- Request priority within one cycle: stop > pause > next > play.
- song_sel >= N_SONGS is clamped to 0.

State machine:
- IDLE
  - play_req: cur_song <= clamped song_sel, go to START.
  - next_req: cur_song <= (cur_song+1) mod N_SONGS, stay IDLE.
- START (exactly 1 cycle)
  - mem_read_rst[cur_song]=1; mem_read_en=0; prime counter cleared; go to PRIME.
- PRIME
  - mem_read_en[cur_song]=1.
  - mem_ready[cur_song]=1 → go to PLAY.
  - Counter reaches PRIME_TIMEOUT without ready → song_done pulse, end-of-song handling.
- PLAY
  - mem_read_en[cur_song]=1.
  - note_out <= mem_data slice of cur_song; note_valid <= mem_ready[cur_song]. This adds 1 cycle of latency relative to the memory.
  - mem_ready[cur_song] falls 1→0 → song_done pulse, end-of-song handling.
- PAUSE
  - mem_read_en=0 (memory holds pointer and sample counter); note_valid=0; note_out holds.
  - play_req → PLAY (no read_rst).

Request handling by state:
- pause_req: PLAY → PAUSE; ignored in all other states.
- stop_req: from any non-IDLE state, pulse mem_read_rst[cur_song] for 1 cycle, drop read_en and note_valid, go to IDLE. cur_song is retained.
- next_req: in PLAY, PAUSE or PRIME, stop the current song (read_rst pulse), set cur_song <= cur_song+1 with wrap at N_SONGS-1 → 0, go to START. No song_done pulse.
- play_req in START, PRIME or PLAY is ignored.

End-of-song handling (without macro):
- Pulse mem_read_rst[cur_song] 1 cycle, go to IDLE.

Invariants:
- At most one bit of mem_read_en is ever set.
- mem_read_en and mem_read_rst are never set for the same index in the same cycle.
- Non-selected memories see read_en=0 always.
- rst asserted mid-song returns everything to reset values next cycle. It does not drive mem_read_rst; memories have their own reset.

Optional Feature:
- Macro SCHED_AUTO_ADVANCE_EN.
- Defined: end-of-song (including empty-song timeout) pulses song_done, advances cur_song with wrap, and enters START. The result is continuous playlist playback until stop_req.
  - If all N_SONGS memories timeout consecutively, go to IDLE. A 2-bit-wider empty-run counter tracks this and is cleared on entering PLAY.
- Undefined: end-of-song returns to IDLE; the empty-run counter is not built.

Test Plan:
- Reset, then play_req with song_sel=1, mem_ready[1] rising 2 cycles later:
  - mem_read_rst=4'b0010 for 1 cycle.
  - mem_read_en=4'b0010 from the next cycle.
  - note_valid=1 one cycle after mem_ready[1]; note_out equals slice 1 (e.g. 10'b0001000010).
- Playing song 1, pause_req:
  - Next cycle mem_read_en=0, note_valid=0, state_o=4.
  - Then play_req: state_o=3, read_en=4'b0010, no read_rst pulse.
- Playing song 3 with next_req:
  - read_rst=4'b1000, cur_song=0, START then PRIME with read_en=4'b0001.
- Song 2 with mem_ready held 0:
  - After 8 PRIME cycles song_done=1 for 1 cycle, state_o=0.
  - With SCHED_AUTO_ADVANCE_EN defined, instead cur_song=3 and START.
- Playing song 0, mem_ready[0] falls:
  - song_done pulse, read_rst=4'b0001, state_o=0.
  - With macro defined, cur_song=1 and playback continues.
- stop_req and next_req asserted in the same cycle while playing:
  - Stop wins: state_o=0, cur_song unchanged.
  - rst asserted mid-PLAY: all outputs zero next cycle.
